// File: rtl/mwc_pkg.sv
// mwc_pkg: shared state encoding and fail-code constants for mem_write_checker.
// Rev 1.0
`default_nettype none

package mwc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_DATA    = 2'd1;
  localparam logic [1:0] FC_ADDR    = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;

endpackage

`default_nettype wire

// File: rtl/mwc_if.sv
// mwc_if: expectation-load, start, processor store port and verdict signals.
// Rev 1.0
`default_nettype none

interface mwc_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             load_en;
  logic [IW-1:0]    load_idx;
  logic [WIDTH-1:0] load_adr;
  logic [WIDTH-1:0] load_data;
  logic [CW-1:0]    exp_count;
  logic             start;
  logic             memwrite;
  logic [WIDTH-1:0] dataadr;
  logic [WIDTH-1:0] writedata;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [1:0]       fail_code;
  logic [CW-1:0]    match_idx;
  logic [WIDTH-1:0] bad_adr;
  logic [WIDTH-1:0] bad_data;

  modport master (
    output load_en, load_idx, load_adr, load_data, exp_count, start,
    output memwrite, dataadr, writedata,
    input  busy, done, pass, fail, fail_code, match_idx, bad_adr, bad_data
  );

  modport slave (
    input  load_en, load_idx, load_adr, load_data, exp_count, start,
    input  memwrite, dataadr, writedata,
    output busy, done, pass, fail, fail_code, match_idx, bad_adr, bad_data
  );

endinterface

`default_nettype wire

// File: rtl/mwc_expect_mem.sv
// mwc_expect_mem: DEPTH x (address, data) expectation slots, sync write, async read.
// Rev 1.0
`default_nettype none

module mwc_expect_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int IW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  wire logic             clk,
  input  wire logic             we_i,
  input  wire logic [IW-1:0]    widx_i,
  input  wire logic [WIDTH-1:0] wadr_i,
  input  wire logic [WIDTH-1:0] wdata_i,
  input  wire logic [CW-1:0]    ridx_i,
  output logic      [WIDTH-1:0] radr_o,
  output logic      [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] adr_q  [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];

  // Slots are deliberately not reset; they are only meaningful once loaded.
  always_ff @(posedge clk) begin
    if (we_i) begin
      adr_q[widx_i]  <= wadr_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  always_comb begin
    radr_o  = '0;
    rdata_o = '0;
    if (ridx_i < CW'(DEPTH)) begin
      radr_o  = adr_q[ridx_i[IW-1:0]];
      rdata_o = data_q[ridx_i[IW-1:0]];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_write_checker.sv
// mem_write_checker: compares the data-memory store stream against loaded expectations.
// Rev 1.0
`default_nettype none

module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024,
  parameter int STRICT  = 1
) (
  input wire logic clk,
  input wire logic reset,
  mwc_if.slave     bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    match_q, match_d;
  logic [1:0]       code_q, code_d;
  logic [WIDTH-1:0] bad_adr_q, bad_adr_d;
  logic [WIDTH-1:0] bad_data_q, bad_data_d;

  logic [CW-1:0]    start_cnt;
  logic [WIDTH-1:0] exp_adr, exp_data;

  assign start_cnt = (bus.exp_count > DEPTH_C) ? DEPTH_C : bus.exp_count;

  mwc_expect_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IW(IW), .CW(CW)) u_mem (
    .clk     (clk),
    .we_i    (bus.load_en && (state_q == ST_IDLE)),
    .widx_i  (bus.load_idx),
    .wadr_i  (bus.load_adr),
    .wdata_i (bus.load_data),
    .ridx_i  (match_q),
    .radr_o  (exp_adr),
    .rdata_o (exp_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    count_d    = count_q;
    match_d    = match_q;
    code_d     = code_q;
    bad_adr_d  = bad_adr_q;
    bad_data_d = bad_data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          count_d = start_cnt;
          match_d = '0;
          cnt_d   = '0;
          state_d = (start_cnt == '0) ? ST_PASS : ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (cnt_q != TO_MAX) cnt_d = cnt_q + TW'(1);
        if (bus.memwrite) begin
          if (bus.dataadr == exp_adr) begin
            if (bus.writedata == exp_data) begin
              match_d = match_q + CW'(1);
              if (match_q + CW'(1) == count_q) state_d = ST_PASS;
            end else begin
              state_d    = ST_FAIL;
              code_d     = FC_DATA;
              bad_adr_d  = bus.dataadr;
              bad_data_d = bus.writedata;
            end
          end else if (STRICT != 0) begin
            state_d    = ST_FAIL;
            code_d     = FC_ADDR;
            bad_adr_d  = bus.dataadr;
            bad_data_d = bus.writedata;
          end
        end
        // A store verdict in the same cycle takes precedence over the timeout.
        if ((state_d == ST_CHECK) && (TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          state_d    = ST_FAIL;
          code_d     = FC_TIMEOUT;
          bad_adr_d  = '0;
          bad_data_d = '0;
        end
      end
      ST_PASS, ST_FAIL: begin
        if (bus.start) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          match_d    = '0;
          code_d     = FC_NONE;
          bad_adr_d  = '0;
          bad_data_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      count_q    <= '0;
      match_q    <= '0;
      code_q     <= FC_NONE;
      bad_adr_q  <= '0;
      bad_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      match_q    <= match_d;
      code_q     <= code_d;
      bad_adr_q  <= bad_adr_d;
      bad_data_q <= bad_data_d;
    end
  end

  assign bus.busy      = (state_q == ST_CHECK);
  assign bus.done      = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign bus.pass      = (state_q == ST_PASS);
  assign bus.fail      = (state_q == ST_FAIL);
  assign bus.fail_code = code_q;
  assign bus.match_idx = match_q;
  assign bus.bad_adr   = bad_adr_q;
  assign bus.bad_data  = bad_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: three checker instances (strict, lenient, strict with short timeout).
// Rev 1.0
`default_nettype none

module tb_mem_write_checker;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          load_en = 1'b0;
  logic [1:0]    load_idx = '0;
  logic [W-1:0]  load_adr = '0, load_data = '0;
  logic [CW-1:0] exp_count = '0;
  logic          start = 1'b0;
  logic          memwrite = 1'b0;
  logic [W-1:0]  dataadr = '0, writedata = '0;

  logic [2:0]    busy_v, done_v, pass_v, fail_v;
  logic [1:0]    code_v    [3];
  logic [CW-1:0] match_v   [3];
  logic [W-1:0]  badadr_v  [3];
  logic [W-1:0]  baddata_v [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instance 0: strict, TIMEOUT 1024. Instance 1: lenient. Instance 2: strict, TIMEOUT 16.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mwc_if #(.WIDTH(W), .DEPTH(D)) u_if ();
    assign u_if.load_en   = load_en;
    assign u_if.load_idx  = load_idx;
    assign u_if.load_adr  = load_adr;
    assign u_if.load_data = load_data;
    assign u_if.exp_count = exp_count;
    assign u_if.start     = start;
    assign u_if.memwrite  = memwrite;
    assign u_if.dataadr   = dataadr;
    assign u_if.writedata = writedata;
    assign busy_v[g]      = u_if.busy;
    assign done_v[g]      = u_if.done;
    assign pass_v[g]      = u_if.pass;
    assign fail_v[g]      = u_if.fail;
    assign code_v[g]      = u_if.fail_code;
    assign match_v[g]     = u_if.match_idx;
    assign badadr_v[g]    = u_if.bad_adr;
    assign baddata_v[g]   = u_if.bad_data;
    mem_write_checker #(
      .WIDTH(W), .DEPTH(D),
      .TIMEOUT((g == 2) ? 16 : 1024),
      .STRICT((g == 1) ? 0 : 1)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
    );
  end

  typedef struct {
    logic          pass;
    logic          fail;
    logic [1:0]    code;
    logic [CW-1:0] match;
    logic [W-1:0]  badadr;
    logic [W-1:0]  baddata;
  } res_t;

  typedef struct {
    logic [W-1:0] sadr, sdata;
    logic [W-1:0] aadr, adata;
    res_t         es, el;
  } vec_t;

  vec_t vt [7];
  res_t sb [$];

  function automatic res_t mk(input logic p, input logic f, input logic [1:0] c,
                              input logic [CW-1:0] m, input logic [W-1:0] ba,
                              input logic [W-1:0] bd);
    res_t r;
    r.pass = p; r.fail = f; r.code = c; r.match = m; r.badadr = ba; r.baddata = bd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string nm, input int k, input res_t e);
    chk({nm, ".pass"},     W'(pass_v[k]),  W'(e.pass));
    chk({nm, ".fail"},     W'(fail_v[k]),  W'(e.fail));
    chk({nm, ".code"},     W'(code_v[k]),  W'(e.code));
    chk({nm, ".match"},    W'(match_v[k]), W'(e.match));
    chk({nm, ".bad_adr"},  badadr_v[k],    e.badadr);
    chk({nm, ".bad_data"}, baddata_v[k],   e.baddata);
  endtask

  task automatic chk_zero(input string nm, input int k);
    chk({nm, ".busy"}, W'(busy_v[k]), '0);
    chk({nm, ".done"}, W'(done_v[k]), '0);
    chk_res(nm, k, mk(0, 0, 2'd0, '0, '0, '0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic load(input logic [1:0] idx, input logic [W-1:0] a, input logic [W-1:0] d);
    load_en = 1'b1; load_idx = idx; load_adr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic arm(input logic [CW-1:0] n);
    exp_count = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic store(input logic [W-1:0] a, input logic [W-1:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int k);
    int n = 0;
    while (!done_v[k] && n < 20) begin
      tick();
      n++;
    end
    if (!done_v[k]) begin
      total++;
      bad++;
      $display("FAIL %s.wait_done: no verdict after %0d cycles, required done=1", nm, n);
    end
  endtask

  initial begin
    res_t ok1, e;
    int   n;
    ok1 = mk(1, 0, 2'd0, 3'd1, '0, '0);
    vt[0] = '{32'h8, 32'hC, 32'h8,        32'hC,        ok1, ok1};
    vt[1] = '{32'h8, 32'hC, 32'h8,        32'h10,       mk(0,1,2'd1,0,32'h8,32'h10), mk(0,1,2'd1,0,32'h8,32'h10)};
    vt[2] = '{32'h8, 32'hC, 32'h4,        32'h7,        mk(0,1,2'd2,0,32'h4,32'h7), ok1};
    vt[3] = '{32'h8, 32'hC, 32'h80000008, 32'hC,        mk(0,1,2'd2,0,32'h80000008,32'hC), ok1};
    vt[4] = '{32'h8, 32'hC, 32'h8,        32'h8000000C, mk(0,1,2'd1,0,32'h8,32'h8000000C), mk(0,1,2'd1,0,32'h8,32'h8000000C)};
    vt[5] = '{32'h8, 32'hC, 32'h9,        32'hC,        mk(0,1,2'd2,0,32'h9,32'hC), ok1};
    vt[6] = '{32'hFFFFFFFC, 32'hDEADBEEF, 32'hFFFFFFFC, 32'hDEADBEEF, ok1, ok1};

    // Reset state
    #2 reset = 1'b0;
    #1 chk_zero("reset", 0);
    tick();
    reset = 1'b1;
    tick();

    // Table: one expectation, store A then the expected store itself
    for (int i = 0; i < 7; i++) begin
      do_reset();
      load(2'd0, vt[i].sadr, vt[i].sdata);
      arm(3'd1);
      store(vt[i].aadr, vt[i].adata);
      store(vt[i].sadr, vt[i].sdata);
      sb.push_back(vt[i].es);
      sb.push_back(vt[i].el);
      for (int k = 0; k < 2; k++) begin
        wait_done($sformatf("vec%0d.dut%0d", i, k), k);
        e = sb.pop_front();
        chk_res($sformatf("vec%0d.dut%0d", i, k), k, e);
      end
    end

    // jr program, load and start in the same cycle
    do_reset();
    load_en = 1'b1; load_idx = 2'd0; load_adr = 32'h8; load_data = 32'hC;
    exp_count = 3'd1; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    tick(); tick(); tick();
    chk("jr.busy_before", W'(busy_v[0]), 32'd1);
    store(32'h8, 32'hC);
    chk_res("jr", 0, ok1);

    // Rerun without reset, jr broken
    arm(3'd1);
    chk("rerun.done", W'(done_v[0]), 32'd0);
    chk("rerun.match", W'(match_v[0]), 32'd0);
    arm(3'd1);
    tick(); tick();
    chk("jrbad.fail_before", W'(fail_v[0]), 32'd0);
    store(32'h8, 32'h10);
    chk_res("jrbad", 0, mk(0, 1, 2'd1, 3'd0, 32'h8, 32'h10));

    // Two expectations with a stray store first
    do_reset();
    load(2'd0, 32'h8, 32'hC);
    load(2'd1, 32'hC, 32'h5);
    arm(3'd2);
    store(32'h4, 32'h7);
    chk_res("two.strict", 0, mk(0, 1, 2'd2, 3'd0, 32'h4, 32'h7));
    store(32'h8, 32'hC);
    chk("two.lenient.mid_match", W'(match_v[1]), 32'd1);
    chk("two.lenient.mid_busy", W'(busy_v[1]), 32'd1);
    store(32'hC, 32'h5);
    chk_res("two.lenient", 1, mk(1, 0, 2'd0, 3'd2, '0, '0));

    // Timeout: fail rises exactly 16 cycles after the start edge
    do_reset();
    load(2'd0, 32'h8, 32'hC);
    arm(3'd1);
    n = 0;
    while (!fail_v[2] && n < 40) begin
      tick();
      n++;
    end
    chk("timeout.cycles", W'(n), 32'd16);
    chk_res("timeout", 2, mk(0, 1, 2'd3, 3'd0, '0, '0));
    chk("timeout.long_busy", W'(busy_v[0]), 32'd1);

    // Asynchronous reset mid-CHECK
    tick();
    #3 reset = 1'b0;
    #1 chk_zero("midreset", 0);
    chk("midreset.dut2.fail", W'(fail_v[2]), 32'd0);
    @(negedge clk) reset = 1'b1;
    tick();
    arm(3'd0);
    chk("zero.pass", W'(pass_v[0]), 32'd1);
    chk("zero.match", W'(match_v[0]), 32'd0);
    arm(3'd0);
    chk_zero("back_idle", 0);

    // exp_count above DEPTH clamps to DEPTH
    do_reset();
    for (int i = 0; i < 4; i++) load(2'(i), 32'h100 + 32'(i) * 4, 32'h50 + 32'(i));
    arm(3'd7);
    for (int i = 0; i < 3; i++) store(32'h100 + 32'(i) * 4, 32'h50 + 32'(i));
    chk("clamp.busy3", W'(busy_v[0]), 32'd1);
    store(32'h10C, 32'h53);
    chk_res("clamp", 0, mk(1, 0, 2'd0, 3'd4, '0, '0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable self-check monitor that sits beside the single-cycle processor's data-memory write port (memwrite, dataadr, writedata).
- It compares the program's store stream against a loaded list of up to DEPTH expected (address, data) pairs.
- It reports pass or fail, with a cause code and the offending write.
- It generalises the one-shot "expect one store, stop" check to multi-store sequences, a strict/lenient mode and a cycle timeout, so modified-instruction programs (jr, jal, …) can be checked on a bench or an FPGA.

Parameters:
- WIDTH, 32: data and address width.
- DEPTH, 4: maximum number of expected stores.
- TIMEOUT, 1024: cycles allowed after start before fail; 0 disables the timeout.
- STRICT, 1: 1 = any write not matching the next expected pair fails; 0 = non-matching writes are ignored.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_en  in  1  write an expectation slot (accepted only in IDLE).
- load_idx  in  $clog2(DEPTH)  slot index.
- load_adr  in  WIDTH  expected address.
- load_data  in  WIDTH  expected data.
- exp_count  in  $clog2(DEPTH)+1  number of valid slots; sampled on start.
- start  in  1  arm the checker (accepted only in IDLE).
- memwrite  in  1  processor store strobe.
- dataadr  in  WIDTH  store address.
- writedata  in  WIDTH  store data.
- busy  out  1  high in CHECK.
- done  out  1  high in PASS or FAIL.
- pass  out  1  high in PASS.
- fail  out  1  high in FAIL.
- fail_code  out  2  0 = none, 1 = data mismatch, 2 = address mismatch (strict mode only), 3 = timeout.
- match_idx  out  $clog2(DEPTH)+1  number of expectations matched so far.
- bad_adr  out  WIDTH  address of the failing write; 0 on timeout.
- bad_data  out  WIDTH  data of the failing write; 0 on timeout.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0; match_idx=0; timeout counter=0. Slot contents are not reset and are don't-care until loaded.
- All stores are sampled on the rising edge of clk while memwrite=1. One store is evaluated per cycle. Outputs are registered: the verdict is visible the cycle after the deciding store.
- IDLE:
  - load_en writes slot[load_idx].
  - On start: latch exp_count, clear match_idx, clear the counter, go to CHECK.
  - If start and load_en are asserted together: the load completes first, then the checker arms.
  - If exp_count=0 at start: go directly to PASS.
  - If exp_count>DEPTH: clamp to DEPTH.
- CHECK (busy=1): the counter increments every cycle. Let E = slot[match_idx]. For each sampled store:
  - dataadr==E.adr and writedata==E.data: match_idx+1. If the new match_idx==count, go to PASS.
  - dataadr==E.adr and writedata!=E.data: FAIL, code 1, in both modes.
  - dataadr!=E.adr: strict mode → FAIL, code 2; lenient mode → ignored.
  - Address and data compare over the full WIDTH. Addresses are byte addresses and are not aligned by the checker.
  - Timeout: when TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no verdict that cycle, go to FAIL, code 3.
  - Simultaneous final match and timeout in the same cycle: the match wins → PASS.
  - load_en is ignored in CHECK.
- PASS / FAIL: sticky. Writes and loads are ignored. start returns to IDLE (outputs cleared) for a rerun without reset; slots are retained.
- Failing-store capture: bad_adr/bad_data are captured with the failing store. They are 0 for timeout.
- The counter is $clog2(TIMEOUT+1) bits and saturates; it never wraps.
- Reset mid-CHECK aborts immediately to IDLE with all outputs 0.

Decomposition:
- Shared package mwc_pkg: state encoding (IDLE, CHECK, PASS, FAIL) and fail_code constants (FC_NONE, FC_DATA, FC_ADDR, FC_TIMEOUT).
- One natural sub-module, mwc_expect_mem: a DEPTH×(2·WIDTH) register file with a synchronous write port and a combinational read at match_idx.
- The FSM and counter stay in the top module.

Test Plan:
- jr program (addi $2,$0,12; jr $2; addi $2,$2,4; sw $2,8($0)), slot0=(8,12), count=1, strict → pass=1, fail_code=0, match_idx=1.
- Same program with jr broken (store 16 to address 8) → fail=1, code 1, bad_adr=8, bad_data=16, one cycle after the store.
- count=2, slots (8,12),(12,5); stores (4,7),(8,12),(12,5): strict → FAIL code 2, bad_adr=4; lenient → PASS, match_idx=2.
- TIMEOUT=16, count=1, no memwrite → fail code 3 with the fail flag rising exactly 16 cycles after start; bad_adr=0.
- reset driven low mid-CHECK, at an instant not aligned to a clock edge → all outputs 0 immediately. Then start with count=0 → PASS next cycle. Then start again → IDLE with outputs cleared.
